// File: rtl/pdm_pkg.sv
// Shared definitions for the PDM receive path: CIC sizing, sample type and
// the defaults used by the decimator and its bench.
package pdm_pkg;

    typedef logic [15:0] sample_t;

    localparam int      DEC_LOG2_DEFAULT    = 12;
    localparam int      SYNC_STAGES_DEFAULT = 2;
    localparam int      DISCARD_DEFAULT     = 2;
    localparam sample_t SAT_VALUE           = 16'hFFFF;

    // A 2nd-order CIC with ratio 2^d grows by 2*d bits; one extra bit holds full scale.
    function automatic int cic_width(input int dec_log2);
        return 2 * dec_log2 + 1;
    endfunction

endpackage

// File: rtl/pdm_decimator_if.sv
// Sample hand-off between the PDM decimator and the record/DMA consumer.
interface pdm_decimator_if;
    import pdm_pkg::*;

    sample_t sound;
    logic    start;
    logic    overrun;
    logic    ack;
    logic    clr_ovr;

    modport master (
        output sound,
        output start,
        output overrun,
        input  ack,
        input  clr_ovr
    );

    modport slave (
        input  sound,
        input  start,
        input  overrun,
        output ack,
        output clr_ovr
    );

endinterface

// File: rtl/pdm_decimator_cic2_core.sv
// Second-order CIC decimator: two integrators at clk rate, decimation
// counter, and two combs at the output rate. y_stb marks a fresh y.
module cic2_core
    import pdm_pkg::*;
#(
    parameter  int DEC_LOG2 = DEC_LOG2_DEFAULT,
    localparam int W        = cic_width(DEC_LOG2)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         b,
    output logic [W-1:0] y,
    output logic         y_stb
);

    logic [W-1:0]        i1;
    logic [W-1:0]        i2;
    logic [W-1:0]        d1;
    logic [W-1:0]        c1;
    logic [W-1:0]        d2;
    logic [DEC_LOG2-1:0] cnt;
    logic                boundary;
    logic                comb2_due;

    assign boundary = (cnt == '1);

    // Modulo-2^W wrap in every adder is what makes the CIC exact.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i1        <= '0;
            i2        <= '0;
            d1        <= '0;
            c1        <= '0;
            d2        <= '0;
            y         <= '0;
            cnt       <= '0;
            comb2_due <= 1'b0;
            y_stb     <= 1'b0;
        end else if (!en) begin
            i1        <= '0;
            i2        <= '0;
            d1        <= '0;
            c1        <= '0;
            d2        <= '0;
            y         <= '0;
            cnt       <= '0;
            comb2_due <= 1'b0;
            y_stb     <= 1'b0;
        end else begin
            i1        <= i1 + W'(b);
            i2        <= i2 + i1;
            cnt       <= cnt + DEC_LOG2'(1);
            comb2_due <= boundary;
            y_stb     <= comb2_due;
            if (boundary) begin
                c1 <= i2 - d1;
                d1 <= i2;
            end
            if (comb2_due) begin
                y  <= c1 - d2;
                d2 <= c1;
            end
        end
    end

endmodule

// File: rtl/pdm_decimator.sv
// PDM bitstream to unsigned 16-bit PCM: synchroniser, CIC core, start-up
// discard, scaling/saturation and a one-entry valid/ack holding register.
module pdm_decimator
    import pdm_pkg::*;
#(
    parameter int DEC_LOG2    = DEC_LOG2_DEFAULT,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
    parameter int DISCARD     = DISCARD_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            pdm_in,
    pdm_decimator_if.master bus
);

    localparam int W      = cic_width(DEC_LOG2);
    localparam int DISC_W = (DISCARD > 0) ? $clog2(DISCARD + 1) : 1;
    localparam logic [DISC_W-1:0] DISC_MAX = DISC_W'(DISCARD);

    logic [SYNC_STAGES-1:0] sync;
    logic                   b;
    logic [W-1:0]           y;
    logic                   y_stb;
    logic [W+14:0]          y_ext;
    sample_t                scaled;
    logic [DISC_W-1:0]      disc;
    logic                   load;
    sample_t                sound_q;
    logic                   start_q;
    logic                   overrun_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pdm_in};
        end
    end

    assign b = sync[SYNC_STAGES-1];

    cic2_core #(
        .DEC_LOG2 (DEC_LOG2)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .b     (b),
        .y     (y),
        .y_stb (y_stb)
    );

    // Top 16 bits below the full-scale bit; short CICs get zero-filled on the right.
    assign y_ext  = {y[W-2:0], 16'h0000};
    assign scaled = y[W-1] ? SAT_VALUE : 16'(y_ext >> (W - 1));

    // The first windows after a restart see a half-filled comb and are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disc <= '0;
        end else if (!en) begin
            disc <= '0;
        end else if (y_stb && (disc != DISC_MAX)) begin
            disc <= disc + DISC_W'(1);
        end
    end

    assign load = en && y_stb && (disc == DISC_MAX);

    // A coincident ack consumed the old sample, so only an unacked overwrite is an overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sound_q   <= '0;
            start_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (load) begin
                sound_q <= scaled;
                start_q <= 1'b1;
            end else if (bus.ack && start_q) begin
                start_q <= 1'b0;
            end
            if (load && start_q && !bus.ack) begin
                overrun_q <= 1'b1;
            end else if (bus.clr_ovr) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign bus.sound   = sound_q;
    assign bus.start   = start_q;
    assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_pdm_decimator.sv
// Directed bench for pdm_decimator: constant, alternating and DAC-loopback
// bitstreams, discard timing, handshake/overrun and reset/enable restarts.
module tb_pdm_decimator;
    import pdm_pkg::*;

    localparam int R = 1 << DEC_LOG2_DEFAULT;

    typedef enum logic [1:0] {SRC_ZERO, SRC_ONE, SRC_ALT, SRC_DAC} src_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        pdm_in;
    src_t        src;
    logic [15:0] dac_acc;
    int          cyc = 0;
    int          base;
    int          compared;
    int          mismatched;

    pdm_decimator_if bus ();

    pdm_decimator #(
        .DEC_LOG2    (DEC_LOG2_DEFAULT),
        .SYNC_STAGES (SYNC_STAGES_DEFAULT),
        .DISCARD     (DISCARD_DEFAULT)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .pdm_in (pdm_in),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Bitstream sources; the DAC is a first-order modulator fed with 0x4000.
    always @(negedge clk) begin
        case (src)
            SRC_ZERO: pdm_in = 1'b0;
            SRC_ONE:  pdm_in = 1'b1;
            SRC_ALT:  pdm_in = ~pdm_in;
            SRC_DAC:  {pdm_in, dac_acc} = {1'b0, dac_acc} + 17'h04000;
            default:  pdm_in = 1'b0;
        endcase
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        compared++;
        assert (obs === exp_v)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic check_range(input string tag, input logic [31:0] obs, input logic [31:0] lo, input logic [31:0] hi);
        compared++;
        assert (obs >= lo && obs <= hi)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h..%h", tag, obs, lo, hi);
        end
    endtask

    // Returns at the falling edge after edge k counted from the last restart.
    task automatic wait_edge(input int k);
        while (cyc < base + k) @(negedge clk);
    endtask

    task automatic apply_stimulus(input logic with_clr);
        bus.ack     = 1'b1;
        bus.clr_ovr = with_clr;
        @(negedge clk);
        bus.ack     = 1'b0;
        bus.clr_ovr = 1'b0;
    endtask

    initial begin
        compared    = 0;
        mismatched  = 0;
        base        = 0;
        rst_n       = 1'b0;
        en          = 1'b0;
        pdm_in      = 1'b1;
        dac_acc     = '0;
        src         = SRC_ONE;
        bus.ack     = 1'b0;
        bus.clr_ovr = 1'b0;

        repeat (3) @(negedge clk);
        check_output("rst_sound", bus.sound, 16'h0000);
        check_output("rst_start", bus.start, 1'b0);
        check_output("rst_overrun", bus.overrun, 1'b0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        $display("[TB] constant ones");
        en   = 1'b1;
        base = cyc;
        wait_edge(3 * R + 1);
        check_output("one_discard_start", bus.start, 1'b0);
        check_output("one_discard_sound", bus.sound, 16'h0000);
        wait_edge(3 * R + 2);
        check_output("one_first_start", bus.start, 1'b1);
        check_output("one_first_sound", bus.sound, 16'hFFFF);
        wait_edge(4 * R + 1);
        bus.ack = 1'b1;
        wait_edge(4 * R + 2);
        bus.ack = 1'b0;
        check_output("ackload_start", bus.start, 1'b1);
        check_output("ackload_overrun", bus.overrun, 1'b0);
        check_output("ackload_sound", bus.sound, 16'hFFFF);

        $display("[TB] enable low with held sample, then alternating bits");
        wait_edge(4 * R + 10);
        en  = 1'b0;
        src = SRC_ALT;
        repeat (5) @(negedge clk);
        check_output("enlow_start", bus.start, 1'b1);
        check_output("enlow_sound", bus.sound, 16'hFFFF);
        apply_stimulus(1'b0);
        check_output("enlow_ack_start", bus.start, 1'b0);
        repeat (4) @(negedge clk);
        en   = 1'b1;
        base = cyc;
        wait_edge(3 * R + 1);
        check_output("alt_discard_start", bus.start, 1'b0);
        check_output("alt_discard_sound", bus.sound, 16'hFFFF);
        wait_edge(3 * R + 2);
        check_output("alt_first_start", bus.start, 1'b1);
        check_output("alt_first_sound", bus.sound, 16'h8000);
        apply_stimulus(1'b0);
        check_output("alt_ack_start", bus.start, 1'b0);
        wait_edge(4 * R + 2);
        check_output("alt_second_start", bus.start, 1'b1);
        check_output("alt_second_sound", bus.sound, 16'h8000);
        wait_edge(5 * R + 2);
        check_output("ovr_start", bus.start, 1'b1);
        check_output("ovr_overrun", bus.overrun, 1'b1);
        check_output("ovr_sound", bus.sound, 16'h8000);
        apply_stimulus(1'b1);
        check_output("clr_start", bus.start, 1'b0);
        check_output("clr_overrun", bus.overrun, 1'b0);
        wait_edge(6 * R + 2);
        check_output("alt_third_start", bus.start, 1'b1);
        check_output("alt_third_sound", bus.sound, 16'h8000);
        check_output("alt_third_overrun", bus.overrun, 1'b0);

        $display("[TB] reset mid-window, then DAC loopback");
        wait_edge(6 * R + 2000);
        rst_n = 1'b0;
        #1;
        check_output("midrst_sound", bus.sound, 16'h0000);
        check_output("midrst_start", bus.start, 1'b0);
        check_output("midrst_overrun", bus.overrun, 1'b0);
        src = SRC_DAC;
        @(negedge clk);
        rst_n = 1'b1;
        base  = cyc;
        wait_edge(3 * R + 1);
        check_output("dac_discard_start", bus.start, 1'b0);
        check_output("dac_discard_sound", bus.sound, 16'h0000);
        wait_edge(3 * R + 2);
        check_output("dac_start", bus.start, 1'b1);
        check_range("dac_sound", bus.sound, 16'h3FFF, 16'h4001);

        $display("[TB] constant zeros");
        wait_edge(3 * R + 10);
        en  = 1'b0;
        src = SRC_ZERO;
        repeat (5) @(negedge clk);
        check_output("enlow2_start", bus.start, 1'b1);
        check_range("enlow2_sound", bus.sound, 16'h3FFF, 16'h4001);
        apply_stimulus(1'b0);
        check_output("enlow2_ack_start", bus.start, 1'b0);
        repeat (4) @(negedge clk);
        en   = 1'b1;
        base = cyc;
        wait_edge(3 * R + 1);
        check_output("zero_discard_start", bus.start, 1'b0);
        wait_edge(3 * R + 2);
        check_output("zero_first_start", bus.start, 1'b1);
        check_output("zero_first_sound", bus.sound, 16'h0000);
        apply_stimulus(1'b0);
        check_output("zero_ack_start", bus.start, 1'b0);
        wait_edge(4 * R + 2);
        check_output("zero_second_start", bus.start, 1'b1);
        check_output("zero_second_sound", bus.sound, 16'h0000);
        check_output("zero_second_overrun", bus.overrun, 1'b0);
        wait_edge(5 * R + 1);
        bus.clr_ovr = 1'b1;
        wait_edge(5 * R + 2);
        bus.clr_ovr = 1'b0;
        check_output("setwins_overrun", bus.overrun, 1'b1);
        check_output("setwins_start", bus.start, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
